spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
SPI mode-0 master that sits directly downstream of the BMP280 controller FSM. It serialises controller bytes onto MOSI and returns MISO bytes with a one-cycle valid strobe. It supports multi-word bursts, with SS either held low across the whole burst (tied) or released between words. Single clock domain; SCLK is derived from clk by a programmable divider.

Parameters:
DATA_BITS, 8, bits per SPI word (MSB first)
CLK_DIV, 4, clk cycles per SCLK half-period (>=2)

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
en  input  1  start request; accepted only when ready_out=1
tied_SS  input  1  1: ss_n held low for the whole burst; 0: ss_n released between words
data_words  input  6  words in burst; 0 treated as 1
data_in  input  DATA_BITS  word to transmit; sampled at start of each word
ready_out  output  1  1 in IDLE, able to accept en
valid_out  output  1  one-cycle pulse per received word
data_out  output  DATA_BITS  last received word; held until next valid_out
sclk  output  1  SPI clock, idle low
mosi  output  1  serial data out
miso  input  1  serial data in
ss_n  output  1  slave select, active low

Behaviour:
- Reset (async, n_rst=0): state IDLE; sclk=0, ss_n=1, mosi=0, ready_out=1, valid_out=0, data_out=0; all counters 0. Reset mid-burst aborts immediately: no valid_out and no partial data_out update.
- Mode 0: MOSI changes on the SCLK falling edge (first bit before the first rising edge). MISO is sampled into the shift register on each SCLK rising edge.
- Divider: counter counts 0..CLK_DIV-1. Each SCLK phase and each SETUP/GAP/HOLD phase lasts exactly CLK_DIV clk cycles.
- States:
  - IDLE: ready_out=1. On en=1:
    - latch tied_SS, words_left = max(data_words,1), shift_tx = data_in.
    - go to SETUP next cycle; ready_out=0 from that cycle.
  - SETUP: ss_n=0, mosi=MSB of shift_tx, sclk=0 for CLK_DIV cycles -> XFER.
  - XFER: DATA_BITS rise/fall pairs; bit counter increments on each falling edge. On the falling edge ending bit DATA_BITS:
    - data_out <= received word; valid_out=1 for that single cycle.
    - decrement words_left.
    - If words remain and tied_SS=1: load shift_tx from data_in in the same cycle and continue XFER with no gap (SS stays low); mosi=new MSB.
    - If words remain and tied_SS=0: go to GAP.
    - If none remain: go to HOLD.
  - GAP: ss_n=1 for CLK_DIV cycles; then load data_in and go to SETUP.
  - HOLD: ss_n=0, sclk=0 for CLK_DIV cycles; then go to IDLE, with ss_n=1 and ready_out=1 in the same cycle.
- Latency: one tied word from en acceptance to valid_out is 1 + CLK_DIV + 2*DATA_BITS*CLK_DIV - 1 clk cycles.
  - CLK_DIV=2, DATA_BITS=8: en at cycle 0 gives valid_out at cycle 34; ready_out returns at cycle 37.
- en while busy: ignored, with no effect on the burst. data_in and data_words changes mid-word are ignored; data_in is sampled only at word boundaries.
- en held high continuously: a new burst starts on the first IDLE cycle.
- words_left is 6 bits; max 63 words per burst; no wrap.

Test Plan:
- Single word, CLK_DIV=2: en with data_in=0xD0, data_words=1; slave drives 0x58 on miso -> mosi shows 1101_0000 on rising edges; one valid_out with data_out=0x58 at cycle 34; ss_n low 36 cycles; ready_out=1 at cycle 37.
- Tied burst: tied_SS=1, data_words=2, data_in 0xD0 then 0x00 at the boundary; slave returns 0xFF, 0x58 -> two valid_out pulses 32 cycles apart (0xFF, 0x58); ss_n never high between words; 16 SCLK rising edges total.
- Untied burst: tied_SS=0, data_words=3 -> three valid_out pulses; ss_n high for exactly CLK_DIV cycles after each of the first two words.
- Busy/zero: data_words=0 -> exactly one word transferred. en pulsed mid-transfer -> no extra word and ready_out stays 0.
- Reset mid-word: n_rst low after 3 SCLK edges -> ss_n=1, sclk=0 asynchronously; no valid_out; data_out unchanged; after release, a new 0xA5 transfer completes correctly.
- Divider: CLK_DIV=5 -> every SCLK high and low phase measures 5 clk cycles; the received byte is correct.

Source files
------------

// File: rtl/spi_master.sv
// SPI mode-0 master: serialises DATA_BITS words MSB first, returns each received word with a one-cycle valid strobe.
// Supports multi-word bursts with slave select either held low throughout (tied) or released for CLK_DIV cycles between words.
module spi_master #(
  parameter int DATA_BITS = 8,
  parameter int CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 en,
  input  logic                 tied_SS,
  input  logic [5:0]           data_words,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 ready_out,
  output logic                 valid_out,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
  output logic                 ss_n
);

  localparam int DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BitW = $clog2(DATA_BITS + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivPre  = DivW'(CLK_DIV - 2);
  localparam logic [BitW-1:0] BitsAll = BitW'(DATA_BITS);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, GAP, HOLD} state_t;

  state_t               state_q, state_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [5:0]           words_q, words_d;
  logic                 tied_q, tied_d;
  logic [DATA_BITS-1:0] tx_q, tx_d;
  logic [DATA_BITS-1:0] rx_q, rx_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 sclk_q, sclk_d;
  logic                 ss_n_q, ss_n_d;
  logic                 valid_q, valid_d;
  logic                 phase_end, pre_end;

  assign phase_end = (div_q == DivLast);
  assign pre_end   = (div_q == DivPre);

  assign ready_out = (state_q == IDLE);
  assign valid_out = valid_q;
  assign data_out  = dout_q;
  assign sclk      = sclk_q;
  assign ss_n      = ss_n_q;
  assign mosi      = tx_q[DATA_BITS-1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      words_q <= '0;
      tied_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      sclk_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      words_q <= words_d;
      tied_q  <= tied_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      sclk_q  <= sclk_d;
      ss_n_q  <= ss_n_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = phase_end ? '0 : div_q + DivW'(1);
    bit_d   = bit_q;
    words_d = words_q;
    tied_d  = tied_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    sclk_d  = sclk_q;
    ss_n_d  = ss_n_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (en) begin
          tied_d  = tied_SS;
          words_d = (data_words == 6'd0) ? 6'd1 : data_words;
          tx_d    = data_in;
          bit_d   = '0;
          ss_n_d  = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (phase_end) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[DATA_BITS-2:0], miso};
          state_d = XFER;
        end
      end
      XFER: begin
        if (sclk_q) begin
          if (phase_end) begin
            sclk_d = 1'b0;
            tx_d   = {tx_q[DATA_BITS-2:0], 1'b0};
            bit_d  = bit_q + BitW'(1);
          end
        end else begin
          // Strobe lands on the last low cycle so valid_out coincides with the word boundary.
          if (pre_end && bit_q == BitsAll) begin
            valid_d = 1'b1;
            dout_d  = rx_q;
          end
          if (phase_end) begin
            if (bit_q == BitsAll) begin
              bit_d   = '0;
              words_d = words_q - 6'd1;
              if (words_q > 6'd1 && tied_q) begin
                tx_d   = data_in;
                sclk_d = 1'b1;
                rx_d   = {rx_q[DATA_BITS-2:0], miso};
              end else if (words_q > 6'd1) begin
                ss_n_d  = 1'b1;
                state_d = GAP;
              end else begin
                state_d = HOLD;
              end
            end else begin
              sclk_d = 1'b1;
              rx_d   = {rx_q[DATA_BITS-2:0], miso};
            end
          end
        end
      end
      GAP: begin
        if (phase_end) begin
          tx_d    = data_in;
          ss_n_d  = 1'b0;
          state_d = SETUP;
        end
      end
      HOLD: begin
        if (phase_end) begin
          ss_n_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: vector table of single words, tied/untied bursts, busy and reset corners on a CLK_DIV=2 instance,
// plus SCLK phase timing on a CLK_DIV=5 instance. Received and transmitted words go through a scoreboard.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       en = 1'b0;
  logic       tied_SS = 1'b0;
  logic [5:0] data_words = 6'd1;
  logic [7:0] data_in = 8'h00;
  logic       ready_out, valid_out, sclk, mosi, miso, ss_n;
  logic [7:0] data_out;
  logic       b_en = 1'b0;
  logic       b_ready, b_valid, b_sclk, b_mosi, b_miso, b_ss_n;
  logic [7:0] b_dout;

  spi_master #(.DATA_BITS(8), .CLK_DIV(2)) dut (
    .clk(clk), .n_rst(n_rst), .en(en), .tied_SS(tied_SS), .data_words(data_words),
    .data_in(data_in), .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n));

  spi_master #(.DATA_BITS(8), .CLK_DIV(5)) dut5 (
    .clk(clk), .n_rst(n_rst), .en(b_en), .tied_SS(tied_SS), .data_words(data_words),
    .data_in(data_in), .ready_out(b_ready), .valid_out(b_valid), .data_out(b_dout),
    .sclk(b_sclk), .mosi(b_mosi), .miso(b_miso), .ss_n(b_ss_n));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: a flat bit stream indexed by SCLK falling edges since the master left IDLE.
  logic [7:0] slv_mem [64];
  logic [8:0] slv_idx = '0;
  assign miso = slv_mem[slv_idx[8:3]][3'd7 - slv_idx[2:0]];

  logic [7:0] tx_w [4];
  logic [7:0] rx_w [4];
  logic [7:0] exp_rx_q [$];
  logic [7:0] exp_tx_q [$];
  logic [7:0] obs_rx_q [$];
  logic [7:0] obs_tx_q [$];
  int         obs_vcyc_q [$];
  int         obs_gap_q [$];

  logic       prev_sclk = 1'b0, prev_rdy = 1'b1;
  logic [7:0] mosi_sh = '0;
  int t0 = 0, rise_cnt = 0, rise_bits = 0, ss_low = 0, gap_cur = 0, ready_cyc = 0;

  always @(negedge clk) begin
    prev_sclk <= sclk;
    prev_rdy  <= ready_out;
    if (!n_rst) begin
      rise_bits <= 0;
      gap_cur   <= 0;
    end else if (en && ready_out) begin
      t0 <= cyc; rise_cnt <= 0; rise_bits <= 0; ss_low <= 0; gap_cur <= 0;
    end else begin
      if (sclk && !prev_sclk) begin
        rise_cnt <= rise_cnt + 1;
        mosi_sh  <= {mosi_sh[6:0], mosi};
        if (rise_bits == 7) begin
          obs_tx_q.push_back({mosi_sh[6:0], mosi});
          rise_bits <= 0;
        end else rise_bits <= rise_bits + 1;
      end
      if (!ss_n) ss_low <= ss_low + 1;
      if (ss_n && !ready_out) gap_cur <= gap_cur + 1;
      else if (gap_cur != 0) begin
        obs_gap_q.push_back(gap_cur);
        gap_cur <= 0;
      end
      if (valid_out) begin
        obs_rx_q.push_back(data_out);
        obs_vcyc_q.push_back(cyc - t0);
      end
      if (ready_out && !prev_rdy) ready_cyc <= cyc - t0;
    end
    if (ready_out) slv_idx <= '0;
    else if (!sclk && prev_sclk) slv_idx <= slv_idx + 9'd1;
  end

  // CLK_DIV=5 instance: phase-length and word monitor.
  logic [7:0] b_word = 8'h00;
  logic [7:0] b_tx_sh = '0;
  logic [2:0] b_idx = '0;
  logic       b_prev = 1'b0, b_seen = 1'b0;
  int b_run = 0, b_t0 = 0;
  int b_high_q [$];
  int b_low_q [$];
  int b_vcyc_q [$];
  logic [7:0] b_rx_q [$];
  logic [7:0] b_exp_q [$];
  assign b_miso = b_word[3'd7 - b_idx];

  always @(negedge clk) begin
    b_prev <= b_sclk;
    if (b_ready) begin
      b_idx <= '0; b_seen <= 1'b0; b_run <= 0;
      if (b_en) b_t0 <= cyc;
    end else begin
      if (b_sclk != b_prev) begin
        if (b_sclk) begin
          if (b_seen) b_low_q.push_back(b_run);
          b_seen  <= 1'b1;
          b_tx_sh <= {b_tx_sh[6:0], b_mosi};
        end else begin
          b_high_q.push_back(b_run);
          b_idx <= b_idx + 3'd1;
        end
        b_run <= 1;
      end else b_run <= b_run + 1;
      if (b_valid) begin
        b_rx_q.push_back(b_dout);
        b_vcyc_q.push_back(cyc - b_t0);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pop_vcyc();
    return (obs_vcyc_q.size() != 0) ? obs_vcyc_q.pop_front() : -1;
  endfunction

  task automatic burst(input logic t, input logic [5:0] nw, input int cnt, input logic poke);
    int n;
    logic [7:0] got;
    for (int k = 0; k < cnt; k++) begin
      slv_mem[k] = rx_w[k];
      exp_rx_q.push_back(rx_w[k]);
      exp_tx_q.push_back(tx_w[k]);
    end
    tied_SS = t; data_words = nw; data_in = tx_w[0]; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; data_in = ~tx_w[0];
    if (poke) begin
      repeat (10) @(posedge clk);
      #1;
      chk("busy_ready", ready_out, 0);
      en = 1'b1; data_in = 8'h77;
      @(posedge clk); #1;
      chk("busy_ready_after_en", ready_out, 0);
      en = 1'b0;
    end
    for (int k = 1; k < cnt; k++) begin
      n = 0;
      while (!valid_out && n < 200) begin @(posedge clk); #1; n++; end
      chk("valid_seen", valid_out, 1);
      data_in = tx_w[k];
      repeat (8) @(posedge clk);
      #1 data_in = ~tx_w[k];
    end
    n = 0;
    while (!ready_out && n < 400) begin @(posedge clk); #1; n++; end
    chk("ready_back", ready_out, 1);
    @(posedge clk); #1;
    chk("n_valid", obs_rx_q.size(), cnt);
    while (exp_rx_q.size() != 0) begin
      got = (obs_rx_q.size() != 0) ? obs_rx_q.pop_front() : 8'hxx;
      chk("rx_word", got, exp_rx_q.pop_front());
    end
    while (exp_tx_q.size() != 0) begin
      got = (obs_tx_q.size() != 0) ? obs_tx_q.pop_front() : 8'hxx;
      chk("mosi_word", got, exp_tx_q.pop_front());
    end
    while (obs_rx_q.size() != 0) void'(obs_rx_q.pop_front());
    while (obs_tx_q.size() != 0) void'(obs_tx_q.pop_front());
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    logic [5:0] nw;
    int         vcyc;
    int         rcyc;
    int         sslow;
    int         rises;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   v0, v1, v2;
    int   n;
    logic [7:0] got;
    vecs[0] = '{8'hD0, 8'h58, 6'd1, 34, 37, 36, 8};
    vecs[1] = '{8'hA5, 8'h5A, 6'd1, 34, 37, 36, 8};
    vecs[2] = '{8'hFF, 8'h00, 6'd0, 34, 37, 36, 8};
    vecs[3] = '{8'h00, 8'hFF, 6'd1, 34, 37, 36, 8};
    vecs[4] = '{8'h81, 8'h7E, 6'd0, 34, 37, 36, 8};
    for (int i = 0; i < 64; i++) slv_mem[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready_out, 1);
    chk("rst_valid", valid_out, 0);
    chk("rst_ss_n", ss_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_data_out", data_out, 0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      tx_w[0] = vecs[i].tx;
      rx_w[0] = vecs[i].rx;
      burst(1'b0, vecs[i].nw, 1, 1'b0);
      chk("vec_valid_cycle", pop_vcyc(), vecs[i].vcyc);
      chk("vec_ready_cycle", ready_cyc, vecs[i].rcyc);
      chk("vec_ss_low", ss_low, vecs[i].sslow);
      chk("vec_rises", rise_cnt, vecs[i].rises);
    end

    tx_w[0] = 8'hD0; tx_w[1] = 8'h00; rx_w[0] = 8'hFF; rx_w[1] = 8'h58;
    burst(1'b1, 6'd2, 2, 1'b0);
    v0 = pop_vcyc(); v1 = pop_vcyc();
    chk("tied_first_valid", v0, 34);
    chk("tied_spacing", v1 - v0, 32);
    chk("tied_rises", rise_cnt, 16);
    chk("tied_no_ss_gap", obs_gap_q.size(), 0);
    chk("tied_ss_low", ss_low, 68);

    tx_w[0] = 8'h11; tx_w[1] = 8'h22; tx_w[2] = 8'h33;
    rx_w[0] = 8'hC3; rx_w[1] = 8'h3C; rx_w[2] = 8'h99;
    burst(1'b0, 6'd3, 3, 1'b0);
    v0 = pop_vcyc(); v1 = pop_vcyc(); v2 = pop_vcyc();
    chk("untied_v0", v0, 34);
    chk("untied_v1", v1, 70);
    chk("untied_v2", v2, 106);
    chk("untied_rises", rise_cnt, 24);
    chk("untied_n_gaps", obs_gap_q.size(), 2);
    while (obs_gap_q.size() != 0) chk("untied_gap_len", obs_gap_q.pop_front(), 2);

    tx_w[0] = 8'h6E; rx_w[0] = 8'h00;
    burst(1'b0, 6'd1, 1, 1'b1);
    chk("busy_valid_cycle", pop_vcyc(), 34);
    chk("busy_ss_low", ss_low, 36);

    slv_mem[0] = 8'h81;
    data_in = 8'h3C; data_words = 6'd1; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (6) @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_ss_n", ss_n, 1);
    chk("midrst_sclk", sclk, 0);
    chk("midrst_ready", ready_out, 1);
    chk("midrst_valid", valid_out, 0);
    chk("midrst_data_out", data_out, 0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_valid", obs_rx_q.size(), 0);
    while (obs_vcyc_q.size() != 0) void'(obs_vcyc_q.pop_front());
    tx_w[0] = 8'hA5; rx_w[0] = 8'h5A;
    burst(1'b0, 6'd1, 1, 1'b0);
    chk("postrst_valid_cycle", pop_vcyc(), 34);

    b_word = 8'h3C;
    b_exp_q.push_back(8'h3C);
    data_in = 8'h96; data_words = 6'd1; tied_SS = 1'b0; b_en = 1'b1;
    @(posedge clk); #1;
    b_en = 1'b0; data_in = 8'h00;
    n = 0;
    while (!b_ready && n < 300) begin @(posedge clk); #1; n++; end
    chk("div5_ready_back", b_ready, 1);
    @(posedge clk); #1;
    chk("div5_n_valid", b_rx_q.size(), 1);
    got = (b_rx_q.size() != 0) ? b_rx_q.pop_front() : 8'hxx;
    chk("div5_rx_word", got, b_exp_q.pop_front());
    chk("div5_mosi_word", b_tx_sh, 8'h96);
    chk("div5_valid_cycle", (b_vcyc_q.size() != 0) ? b_vcyc_q.pop_front() : -1, 85);
    chk("div5_n_high", b_high_q.size(), 8);
    chk("div5_n_low", b_low_q.size(), 7);
    while (b_high_q.size() != 0) chk("div5_high_len", b_high_q.pop_front(), 5);
    while (b_low_q.size() != 0) chk("div5_low_len", b_low_q.pop_front(), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
